// File: rtl/serial_comparator_pkg.sv
// Shared types, result encodings and the per-beat decision for serial_comparator.
// SERIAL_COMPARATOR_SIGNED_EN selects two's-complement operands (sign beat inverted).
package serial_comparator_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [2:0] CMP_NONE = 3'b000;
   localparam logic [2:0] CMP_GT   = 3'b100;
   localparam logic [2:0] CMP_EQ   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b001;

`ifdef SERIAL_COMPARATOR_SIGNED_EN
   localparam logic SIGNED_EN = 1'b1;
`else
   localparam logic SIGNED_EN = 1'b0;
`endif

   // The first differing bit decides; on a signed sign beat a set bit means the smaller value.
   function automatic logic [2:0] cmp_step(input logic [2:0] cur,
                                           input logic       decided,
                                           input logic       first,
                                           input logic       a,
                                           input logic       b);
      logic a_wins;
      a_wins = a ^ (first & SIGNED_EN);
      if (decided || (a == b))
         return cur;
      return a_wins ? CMP_GT : CMP_LT;
   endfunction

endpackage

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator producing one-hot {A>B, A==B, A<B}.
// Signed mode is enabled by SERIAL_COMPARATOR_SIGNED_EN (see serial_comparator_pkg).
module serial_comparator
   import serial_comparator_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic       in_clk,
   input  logic       in_rst_n,
   input  logic       in_start,
   input  logic       in_bit_valid,
   input  logic       in_bit_A,
   input  logic       in_bit_B,
   output logic       out_busy,
   output logic       out_done,
   output logic [2:0] out_C
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          decided_q;
   logic [2:0]    res_q;
   logic [2:0]    res_d;
   logic          decided_d;
   logic [2:0]    out_C_q;
   logic          busy_q;
   logic          done_q;

   always_comb begin
      res_d     = cmp_step(res_q, decided_q, (cnt_q == '0), in_bit_A, in_bit_B);
      decided_d = decided_q | (in_bit_A ^ in_bit_B);
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         res_q     <= CMP_NONE;
         out_C_q   <= CMP_NONE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (in_start) begin
                  state_q   <= SHIFT;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  decided_q <= 1'b0;
                  res_q     <= CMP_EQ;
               end
            end
            SHIFT: begin
               if (in_bit_valid) begin
                  res_q     <= res_d;
                  decided_q <= decided_d;
                  cnt_q     <= cnt_q + CW'(1);
                  // The last beat's decision goes straight to the output register.
                  if (cnt_q == LAST) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     out_C_q <= res_d;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_busy = busy_q;
   assign out_done = done_q;
   assign out_C    = out_C_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator (WIDTH=3); honours SERIAL_COMPARATOR_SIGNED_EN.
module tb_serial_comparator;

   localparam int unsigned W = 3;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       valid;
   logic       bit_a;
   logic       bit_b;
   logic       busy;
   logic       done;
   logic [2:0] res;

   int tests  = 0;
   int failed = 0;
   logic [2:0] sb[$];

   serial_comparator #(.WIDTH(W)) dut (
      .in_clk      (clk),
      .in_rst_n    (rst_n),
      .in_start    (start),
      .in_bit_valid(valid),
      .in_bit_A    (bit_a),
      .in_bit_B    (bit_b),
      .out_busy    (busy),
      .out_done    (done),
      .out_C       (res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: plain integer comparison of the whole operands.
   function automatic logic [2:0] model(input logic [2:0] a, input logic [2:0] b);
`ifdef SERIAL_COMPARATOR_SIGNED_EN
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
`else
      if (a > b) return 3'b100;
      if (a < b) return 3'b001;
`endif
      return 3'b010;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(1'b0));
         end else begin
            logic [2:0] exp;
            exp = sb.pop_front();
            check("result", 32'(res), 32'(exp));
         end
      end
   end

   // Entered and left at posedge+1.
   task automatic run_op(input logic [2:0] a, input logic [2:0] b, input int gap,
                         input bit start_with_valid, input bit extra_start,
                         input logic [2:0] exp);
      int busy_bad;
      busy_bad = 0;
      sb.push_back(exp);
      start = 1'b1;
      valid = start_with_valid;
      bit_a = 1'b1;
      bit_b = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      valid = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         valid = 1'b1;
         bit_a = a[i];
         bit_b = b[i];
         start = extra_start && (i == int'(W) - 2);
         @(negedge clk);
         if (!busy) busy_bad++;
         @(posedge clk); #1;
         valid = 1'b0;
         start = 1'b0;
         bit_a = ~bit_a;
         bit_b = 1'b0;
         if (i != 0) begin
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               if (!busy) busy_bad++;
               @(posedge clk); #1;
            end
         end
      end
      check("busy_during_shift", 32'(busy_bad), 32'(0));
      @(negedge clk);
      check("done_latency", 32'(done), 32'(1'b1));
      check("busy_after_last", 32'(busy), 32'(1'b0));
      @(posedge clk); #1;
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'(1'b0));
      @(posedge clk); #1;
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      valid = 1'b0;
      bit_a = 1'b0;
      bit_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_C", 32'(res), 32'(3'b000));
      check("reset_busy", 32'(busy), 32'(1'b0));
      check("reset_done", 32'(done), 32'(1'b0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors with hand-computed results
`ifdef SERIAL_COMPARATOR_SIGNED_EN
      run_op(3'b101, 3'b011, 0, 1'b0, 1'b0, 3'b001);
      run_op(3'b110, 3'b110, 0, 1'b0, 1'b0, 3'b010);
      run_op(3'b010, 3'b111, 0, 1'b0, 1'b0, 3'b100);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_idle", 32'(res), 32'(3'b100));
         @(posedge clk); #1;
      end
      run_op(3'b100, 3'b001, 2, 1'b0, 1'b0, 3'b001);
`else
      run_op(3'b101, 3'b011, 0, 1'b0, 1'b0, 3'b100);
      run_op(3'b110, 3'b110, 0, 1'b0, 1'b0, 3'b010);
      run_op(3'b010, 3'b111, 0, 1'b0, 1'b0, 3'b001);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_idle", 32'(res), 32'(3'b001));
         @(posedge clk); #1;
      end
      run_op(3'b100, 3'b001, 2, 1'b0, 1'b0, 3'b100);
`endif

      // Stray start pulses and a beat presented with start must not matter
      run_op(3'b011, 3'b011, 0, 1'b1, 1'b1, 3'b010);
      run_op(3'b001, 3'b000, 1, 1'b1, 1'b1, model(3'b001, 3'b000));

      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            run_op(3'(a), 3'(b), 0, 1'b0, 1'b0, model(3'(a), 3'(b)));
         end
      end

      // Reset after the second beat of an operation
      run_op(3'b111, 3'b000, 0, 1'b0, 1'b0, model(3'b111, 3'b000));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         valid = 1'b1;
         bit_a = 1'b1;
         bit_b = 1'b0;
         @(posedge clk); #1;
      end
      valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midop_reset_out_C", 32'(res), 32'(3'b000));
      check("midop_reset_busy", 32'(busy), 32'(1'b0));
      @(negedge clk);
      check("midop_reset_done", 32'(done), 32'(1'b0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(3'b010, 3'b011, 0, 1'b0, 1'b0, model(3'b010, 3'b011));

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
